// File: rtl/and_64_unit.sv
// Y86-64 execute-stage andq slice: combinational a & b plus a one-cycle registered result.
// Define AND_64_UNIT_CC_EN to build the ZF/SF/OF condition-code registers; otherwise they read 0.
module and_64_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] result_q,
  output logic             out_valid,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  assign out = a & b;

  // result_q only moves on a capture so the EX/MEM register sees a stable value between ops
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result_q <= out;
      end
    end
  end

`ifdef AND_64_UNIT_CC_EN
  logic zf_q;
  logic sf_q;
  logic of_q;

  // logical ops clear OF; ZF/SF come straight from the captured result
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (in_valid) begin
      zf_q <= (out == '0);
      sf_q <= out[WIDTH-1];
      of_q <= 1'b0;
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: tb/tb_and_64_unit.sv
// Scoreboard bench for and_64_unit: the driver pushes per-cycle expectations from a
// bit-by-bit reference model, and a negedge monitor pops and compares the registered outputs.
module tb_and_64_unit;

  typedef struct packed {
    logic        valid;
    logic [63:0] result;
    logic        zf;
    logic        sf;
    logic        of;
  } exp_t;

  logic        clk;
  logic        rstIn;
  logic        validIn;
  logic [63:0] aIn;
  logic [63:0] bIn;
  logic [63:0] out;
  logic [63:0] resultQ;
  logic        outValid;
  logic        zf;
  logic        sf;
  logic        of;

  int compared   = 0;
  int mismatched = 0;

  exp_t expQ[$];

  logic [63:0] modelResult = '0;
  logic        modelZf     = 1'b0;
  logic        modelSf     = 1'b0;

  and_64_unit #(.WIDTH(64)) dut (
    .clk      (clk),
    .rst      (rstIn),
    .in_valid (validIn),
    .a        (aIn),
    .b        (bIn),
    .out      (out),
    .result_q (resultQ),
    .out_valid(outValid),
    .zf       (zf),
    .sf       (sf),
    .of       (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference AND built one bit at a time from shifts and remainders
  function automatic logic [63:0] refAnd(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (((x >> i) % 2 == 1) && ((y >> i) % 2 == 1)) r = r + (64'd1 << i);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // drive one cycle of inputs, check the combinational path, then log what the registers must hold
  task automatic applyStimulus(input logic r, input logic v, input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    @(negedge clk);
    rstIn   = r;
    validIn = v;
    aIn     = x;
    bIn     = y;
    #1;
    checkOutput("comb_out", out, refAnd(x, y));
    @(posedge clk);
    if (r) begin
      modelResult = '0;
      modelZf     = 1'b0;
      modelSf     = 1'b0;
    end else if (v) begin
      modelResult = refAnd(x, y);
`ifdef AND_64_UNIT_CC_EN
      modelZf = (modelResult == 64'd0);
      modelSf = (modelResult >= 64'h8000_0000_0000_0000);
`endif
    end
    e.valid  = !r && v;
    e.result = modelResult;
    e.zf     = modelZf;
    e.sf     = modelSf;
    e.of     = 1'b0;
    expQ.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("out_valid", {63'd0, outValid}, {63'd0, e.valid});
        checkOutput("result_q", resultQ, e.result);
        checkOutput("zf", {63'd0, zf}, {63'd0, e.zf});
        checkOutput("sf", {63'd0, sf}, {63'd0, e.sf});
        checkOutput("of", {63'd0, of}, {63'd0, e.of});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit expired");
  end

  function automatic logic [63:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return {1'b1, 31'($urandom), 32'($urandom)};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin : driver
    rstIn   = 1'b1;
    validIn = 1'b1;
    aIn     = '1;
    bIn     = '1;

    applyStimulus(1'b1, 1'b1, '1, '1);
    applyStimulus(1'b1, 1'b1, '1, '1);

    // asynchronous counting sweep on the combinational path, registers idle
    @(negedge clk);
    rstIn   = 1'b0;
    validIn = 1'b0;
    for (int t = 0; t <= 10; t++) begin
      aIn = 64'(t);
      bIn = 64'(t / 2);
      #1;
      checkOutput("sweep_out", out, refAnd(aIn, bIn));
    end

    applyStimulus(1'b0, 1'b1, 64'h8000_0000_0000_00F0, 64'hF000_0000_0000_0030);
    applyStimulus(1'b0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    applyStimulus(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, '1);
    applyStimulus(1'b0, 1'b1, 64'd1, '1);
    applyStimulus(1'b0, 1'b1, 64'd2, '1);
    applyStimulus(1'b0, 1'b1, 64'd3, '1);
    applyStimulus(1'b1, 1'b1, 64'd4, '1);
    applyStimulus(1'b0, 1'b1, '1, '1);
    applyStimulus(1'b0, 1'b1, 64'd0, '1);

    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                    pickOperand(), pickOperand());
    end

    @(negedge clk);
    #1;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/and_64_unit.md
Name: and_64_unit

Overview:
- 64-bit bitwise-AND slice of the Y86-64 pipeline ALU (execute stage, andq operation).
- Provides a combinational result path plus a one-cycle registered result with a valid flag and Y86 condition codes (ZF, SF, OF).
- Feeds the execute/memory pipeline register and the CC register update logic.

Parameters:
- WIDTH, 64, operand and result width in bits. Only 64 is supported for Y86-64; other values are not required to work.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle; request to capture the result.
- a  input  64  operand A (valA).
- b  input  64  operand B (valB).
- out  output  64  combinational a & b.
- result_q  output  64  registered a & b.
- out_valid  output  1  result_q and flags updated on the previous edge.
- zf  output  1  registered zero flag.
- sf  output  1  registered sign flag.
- of  output  1  registered overflow flag.

Behaviour:
- out[i] = a[i] & b[i] for i = 0..63. Purely combinational, zero latency, independent of clk/rst/in_valid.
- out must follow any a/b change in the same delta cycle; no latches.
- Rising edge with rst=1:
  - result_q=0, out_valid=0, zf=0, sf=0, of=0.
  - rst has priority over in_valid.
  - Reset mid-stream discards the pending capture.
- Rising edge with rst=0 and in_valid=1:
  - result_q <= a & b; out_valid <= 1.
  - zf <= (a & b) == 0; sf <= (a & b)[63]; of <= 0 (logical ops never overflow).
- Rising edge with rst=0 and in_valid=0:
  - out_valid <= 0; result_q, zf, sf, of hold their values.
- Latency: 1 cycle from in_valid to out_valid.
- Throughput: 1 result per cycle, back-to-back in_valid allowed. No backpressure, no stall input.
- Boundary cases:
  - a=0 or b=0 gives zf=1, sf=0.
  - All-ones operands give result 0xFFFF_FFFF_FFFF_FFFF, sf=1, zf=0.
  - Bit 63 is the sign bit; there is no carry or wrap behaviour.
- No X propagation from the registers after the first reset edge.

Optional Feature:
- Macro: AND_64_UNIT_CC_EN.
- Defined: zf/sf/of are computed and registered as described above.
- Undefined:
  - No flag registers are synthesized; zf, sf, of are tied to constant 0.
  - Port list is unchanged.
  - out, result_q and out_valid behave identically to the defined case.

Test Plan:
- Reset: hold rst=1 for 2 edges with in_valid=1, a=b=all-ones -> result_q=0, out_valid=0, zf=sf=of=0. Meanwhile out=0xFFFF_FFFF_FFFF_FFFF combinationally.
- Counting sweep: a increments every 1 ns, b every 2 ns from 0 for 10 ns. Check out == a & b at every step, e.g. a=3, b=1 -> out=1; a=6, b=3 -> out=2; a=5, b=2 -> out=0.
- Registered path: in_valid=1, a=0x8000_0000_0000_00F0, b=0xF000_0000_0000_0030 -> next edge result_q=0x8000_0000_0000_0030, out_valid=1, sf=1, zf=0, of=0.
- Zero flag and hold: in_valid=1, a=0xAAAA_AAAA_AAAA_AAAA, b=0x5555_5555_5555_5555 -> result_q=0, zf=1, sf=0. Next cycle in_valid=0 -> out_valid=0, result_q and zf hold.
- Back-to-back and reset priority: in_valid=1 for 3 cycles with a=1,2,3 and b=all-ones -> result_q=1,2,3 on consecutive edges, out_valid stays 1. Assert rst with in_valid=1 on a 4th edge -> all registered outputs return to 0.
- Without AND_64_UNIT_CC_EN: repeat the registered-path case -> result_q=0x8000_0000_0000_0030, out_valid=1, zf=sf=of=0.
